apb_master_bridge8: RTL and testbench

APB_MASTER_BRIDGE8 -- requirements
Module: apb_master_bridge8

---
 rtl/apb_master_pkg8.sv | 7 +
 rtl/apb_timeout_cnt8.sv | 24 ++
 rtl/apb_master_bridge8.sv | 93 +++++++++
 tb/tb_apb_master_bridge8.sv | 131 +++++++++++++
 4 files changed

// File: rtl/apb_master_pkg8.sv
// apb_master_pkg8: shared FSM state enum and default widths for the APB master bridge
package apb_master_pkg8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_TIMEOUT = 16;
endpackage

// File: rtl/apb_timeout_cnt8.sv
// apb_timeout_cnt8: saturating ACCESS wait-state counter with timeout detect
// Ports: clk, rst_n (async active-low), clear (restart count), enable (a wait cycle),
//        expired (this wait cycle is the LIMIT-th one; never set when LIMIT is 0)
module apb_timeout_cnt8
  import apb_master_pkg8::*;
#(
  parameter int LIMIT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != CW'(LIMIT)) cnt <= cnt + CW'(1);
  // Fires during the wait cycle that brings the count to LIMIT, so the abort
  // happens after exactly LIMIT ACCESS cycles.
  assign expired = (LIMIT != 0) && enable && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/apb_master_bridge8.sv
// apb_master_bridge8: valid/ready command to APB master bridge with wait-state timeout
// Ports: pclock8/preset8 (clock, async active-low reset); cmd_* command handshake in;
//        rsp_* response handshake out; paddr8/prwd8/pwdata8/psel8/penable8 APB out,
//        prdata8/pready8/pslverr8 APB in
module apb_master_bridge8
  import apb_master_pkg8::*;
#(
  parameter int PADDR_WIDTH8 = APB_ADDR_W,
  parameter int PWDATA_WIDTH8 = APB_DATA_W,
  parameter int PRDATA_WIDTH8 = APB_DATA_W,
  parameter int TIMEOUT_CYCLES8 = APB_TIMEOUT
) (
  input  logic                     pclock8,
  input  logic                     preset8,
  input  logic                     cmd_valid8,
  output logic                     cmd_ready8,
  input  logic                     cmd_write8,
  input  logic [PADDR_WIDTH8-1:0]  cmd_addr8,
  input  logic [PWDATA_WIDTH8-1:0] cmd_wdata8,
  output logic                     rsp_valid8,
  input  logic                     rsp_ready8,
  output logic [PRDATA_WIDTH8-1:0] rsp_rdata8,
  output logic                     rsp_slverr8,
  output logic                     rsp_timeout8,
  output logic [PADDR_WIDTH8-1:0]  paddr8,
  output logic                     prwd8,
  output logic [PWDATA_WIDTH8-1:0] pwdata8,
  output logic                     psel8,
  output logic                     penable8,
  input  logic [PRDATA_WIDTH8-1:0] prdata8,
  input  logic                     pready8,
  input  logic                     pslverr8
);
  apb_state_e state;
  logic accept, waiting, expired;
  assign accept = state == IDLE && cmd_valid8 && cmd_ready8;
  assign waiting = state == ACCESS && !pready8;
  apb_timeout_cnt8 #(.LIMIT(TIMEOUT_CYCLES8)) u_cnt (
    .clk(pclock8),
    .rst_n(preset8),
    .clear(accept),
    .enable(waiting),
    .expired(expired)
  );
  always_ff @(posedge pclock8 or negedge preset8)
    if (!preset8) begin
      state <= IDLE;
      cmd_ready8 <= 1'b0;
      rsp_valid8 <= 1'b0;
      psel8 <= 1'b0;
      penable8 <= 1'b0;
      prwd8 <= 1'b0;
      rsp_slverr8 <= 1'b0;
      rsp_timeout8 <= 1'b0;
      paddr8 <= '0;
      pwdata8 <= '0;
      rsp_rdata8 <= '0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            state <= SETUP;
            cmd_ready8 <= 1'b0;
            psel8 <= 1'b1;
            paddr8 <= cmd_addr8;
            prwd8 <= cmd_write8;
            pwdata8 <= cmd_wdata8;
          end else cmd_ready8 <= 1'b1;
        SETUP: begin
          state <= ACCESS;
          penable8 <= 1'b1;
        end
        ACCESS:
          // pready8 wins over a simultaneous timeout because expired needs pready8 low
          if (pready8 || expired) begin
            state <= RESP;
            psel8 <= 1'b0;
            penable8 <= 1'b0;
            rsp_valid8 <= 1'b1;
            rsp_rdata8 <= pready8 && !prwd8 ? prdata8 : '0;
            rsp_slverr8 <= pready8 ? pslverr8 : 1'b1;
            rsp_timeout8 <= !pready8;
          end
        RESP:
          if (rsp_ready8) begin
            state <= IDLE;
            rsp_valid8 <= 1'b0;
            cmd_ready8 <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_master_bridge8.sv
// tb_apb_master_bridge8: directed scoreboard bench for apb_master_bridge8
module tb_apb_master_bridge8;
  logic pclock8 = 1'b0, preset8 = 1'b0;
  logic cmd_valid8 = 1'b0, cmd_write8 = 1'b0, rsp_ready8 = 1'b0;
  logic pready8 = 1'b0, pslverr8 = 1'b0;
  logic [31:0] cmd_addr8 = '0, cmd_wdata8 = '0, prdata8 = '0;
  logic cmd_ready8, rsp_valid8, rsp_slverr8, rsp_timeout8, prwd8, psel8, penable8;
  logic [31:0] rsp_rdata8, paddr8, pwdata8;
  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
  } rsp_t;
  rsp_t sb[$];
  int compared = 0, mismatched = 0;

  always #5 pclock8 = ~pclock8;

  apb_master_bridge8 dut (
    .pclock8(pclock8), .preset8(preset8),
    .cmd_valid8(cmd_valid8), .cmd_ready8(cmd_ready8), .cmd_write8(cmd_write8),
    .cmd_addr8(cmd_addr8), .cmd_wdata8(cmd_wdata8),
    .rsp_valid8(rsp_valid8), .rsp_ready8(rsp_ready8), .rsp_rdata8(rsp_rdata8),
    .rsp_slverr8(rsp_slverr8), .rsp_timeout8(rsp_timeout8),
    .paddr8(paddr8), .prwd8(prwd8), .pwdata8(pwdata8), .psel8(psel8), .penable8(penable8),
    .prdata8(prdata8), .pready8(pready8), .pslverr8(pslverr8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // waits < 0: pready8 never rises; otherwise pready8 high in ACCESS cycle number 'waits'
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic err, input int waits,
                      input int hold, input logic hold_valid);
    int k;
    rsp_t e, seen;
    cmd_valid8 = 1'b1; cmd_write8 = wr; cmd_addr8 = addr; cmd_wdata8 = wdata;
    for (int i = 0; i < 20 && !cmd_ready8; i++) @(negedge pclock8);
    chk("accept_ready", cmd_ready8, 1);
    e.rdata = (waits < 0 || wr) ? 32'h0 : rdata;
    e.slverr = waits < 0 ? 1'b1 : err;
    e.tmo = waits < 0;
    sb.push_back(e);
    @(negedge pclock8);
    cmd_valid8 = 1'b0;
    chk("setup_psel", psel8, 1);
    chk("setup_penable", penable8, 0);
    chk("setup_paddr", paddr8, addr);
    chk("setup_prwd", prwd8, wr);
    chk("setup_pwdata", pwdata8, wdata);
    pready8 = 1'b0; prdata8 = rdata; pslverr8 = err;
    k = 0;
    while (k < 40) begin
      @(negedge pclock8);
      if (rsp_valid8) break;
      chk("access_psel", psel8, 1);
      chk("access_penable", penable8, 1);
      chk("access_paddr", paddr8, addr);
      pready8 = (k == waits);
      k++;
    end
    pready8 = 1'b0; pslverr8 = 1'b0; prdata8 = 32'hA5A5_5A5A;
    chk("rsp_valid", rsp_valid8, 1);
    chk("access_cycles", k, waits < 0 ? 16 : waits + 1);
    chk("resp_psel", {psel8, penable8}, 0);
    seen = {rsp_rdata8, rsp_slverr8, rsp_timeout8};
    cmd_valid8 = hold_valid; cmd_addr8 = ~addr;
    repeat (hold) begin
      @(negedge pclock8);
      chk("hold_rsp_valid", rsp_valid8, 1);
      chk("hold_cmd_ready", cmd_ready8, 0);
      chk("hold_psel", psel8, 0);
      chk("hold_stable", {rsp_rdata8, rsp_slverr8, rsp_timeout8}, seen);
    end
    rsp_ready8 = 1'b1;
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata8, e.rdata);
    chk("rsp_slverr", rsp_slverr8, e.slverr);
    chk("rsp_timeout", rsp_timeout8, e.tmo);
    @(negedge pclock8);
    rsp_ready8 = 1'b0; cmd_valid8 = 1'b0;
    chk("done_rsp_valid", rsp_valid8, 0);
    chk("done_cmd_ready", cmd_ready8, 1);
    chk("done_psel", psel8, 0);
    chk("paddr_retain", paddr8, addr);
  endtask

  initial begin
    @(negedge pclock8);
    chk("rst_ctrl", {cmd_ready8, rsp_valid8, psel8, penable8, prwd8, rsp_slverr8, rsp_timeout8}, 0);
    chk("rst_data", {paddr8, pwdata8}, 0);
    chk("rst_rdata", rsp_rdata8, 0);
    preset8 = 1'b1;
    @(negedge pclock8);
    chk("first_cmd_ready", cmd_ready8, 1);
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0, 1'b0);
    xfer(1'b0, 32'h0000_0024, 32'h0, 32'h1234_5678, 1'b0, 3, 0, 1'b0);
    xfer(1'b0, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 0, 1'b0);
    xfer(1'b0, 32'h0000_0044, 32'h0, 32'h5555_AAAA, 1'b0, -1, 0, 1'b0);
    xfer(1'b1, 32'h0000_0050, 32'h0BAD_F00D, 32'h0, 1'b0, 0, 5, 1'b1);
    xfer(1'b0, 32'h0000_0060, 32'h0, 32'h7777_1111, 1'b0, 15, 0, 1'b0);
    cmd_valid8 = 1'b1; cmd_write8 = 1'b0; cmd_addr8 = 32'h0000_0070;
    for (int i = 0; i < 20 && !cmd_ready8; i++) @(negedge pclock8);
    @(negedge pclock8);
    cmd_valid8 = 1'b0; pready8 = 1'b0;
    @(negedge pclock8);
    chk("pre_rst_penable", {psel8, penable8}, 2'b11);
    #2 preset8 = 1'b0;
    #1;
    chk("async_rst_psel", {psel8, penable8}, 0);
    chk("async_rst_ctrl", {cmd_ready8, rsp_valid8}, 0);
    chk("async_rst_paddr", paddr8, 0);
    @(negedge pclock8);
    @(negedge pclock8);
    chk("in_rst_rsp_valid", rsp_valid8, 0);
    preset8 = 1'b1;
    @(negedge pclock8);
    chk("rel_cmd_ready", cmd_ready8, 1);
    chk("rel_rsp_valid", rsp_valid8, 0);
    xfer(1'b0, 32'h0000_0080, 32'h0, 32'h0F0F_F0F0, 1'b0, 2, 1, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
